tile_mode_sequencer: RTL and testbench
======================================

Name: tile_mode_sequencer

Overview:
- Parametrised, registered successor to the combinational array-mode decoder.
- Accepts a GEMM job descriptor (ksize, nsize) via a start pulse and classifies it into the same four array modes with the same operand-mux selects.
- Walks the job as a sequence of array-sized tiles, issued over a valid/ready handshake to the datapath controller.
- Sits between the job front-end and the systolic array control/feeder logic.

Parameters:
- SYS_ROWS, 4: array rows; K-dimension tile size; Tallwave threshold.
- SYS_COLS, 4: array columns; N-dimension tile size; Widewave threshold.
- DIM_W, 8: width of ksize, nsize, tile bases and tile extents.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  job request; accepted only in IDLE.
- ksize  input  DIM_W  K dimension; sampled on accepted start.
- nsize  input  DIM_W  N dimension; sampled on accepted start.
- busy  output  1  high from the cycle after accept through the done cycle.
- err  output  1  one-cycle pulse when start carries ksize==0 or nsize==0.
- mode  output  2  registered mode: 00 = !Tall&Wide, 01 = !Tall&!Wide, 10 = Tall&Wide, 11 = Tall&!Wide.
- if_mux_sel  output  1  1 when !Tall, else 0.
- w_mux_sel  output  1  1 when Tall, else 0.
- tile_valid  output  1  tile descriptor valid.
- tile_ready  input  1  consumer accepts the tile.
- tile_k_base  output  DIM_W  K offset of the current tile.
- tile_n_base  output  DIM_W  N offset of the current tile.
- tile_k_rows  output  DIM_W  valid rows in the tile, 1..SYS_ROWS.
- tile_n_cols  output  DIM_W  valid cols in the tile, 1..SYS_COLS.
- tile_last  output  1  current tile is the final tile of the job.
- done  output  1  one-cycle pulse after the last tile handshake.

Behaviour:
- Reset: async assert drives state=IDLE and every output and internal register to 0 (mode=00, selects 0), regardless of the current state.
- Classification:
  - Tall = (ksize <= SYS_ROWS); Wide = (nsize > SYS_COLS).
  - Computed on the latched sizes; mode and selects are stable from DECODE until the next accepted start.
- FSM:
  - IDLE: on start with both sizes nonzero, latch sizes and go to DECODE. On start with either size zero, pulse err the next cycle, stay IDLE, leave mode unchanged. busy=0.
  - DECODE, 1 cycle: register mode and selects, clear k_base and n_base, go to ISSUE.
  - ISSUE: tile_valid=1. Descriptor holds stable while tile_ready=0. On tile_valid&tile_ready:
    - if tile_last, go to DONE;
    - else if the current K tile is the last in K, clear k_base and add SYS_COLS to n_base;
    - else add SYS_ROWS to k_base.
  - DONE, 1 cycle: done=1, busy=1, then IDLE.
- Latency: start accepted in cycle t; mode valid t+1; first tile_valid t+2; done exactly 1 cycle after the final handshake. Back-to-back tiles with ready held high issue one per cycle.
- Tile order: N outer, K inner (partial-sum accumulation across K per column block).
- Arithmetic:
  - Last in K when k_base + SYS_ROWS >= ksize; last in N when n_base + SYS_COLS >= nsize.
  - Sums are computed at DIM_W+1 bits, so bases near 2^DIM_W-1 cannot wrap.
  - tile_k_rows = min(SYS_ROWS, ksize - k_base); tile_n_cols = min(SYS_COLS, nsize - n_base).
  - tile_last = last in K AND last in N; combinational from registered state.
- Boundary conditions:
  - start outside IDLE is ignored; latched sizes are not disturbed.
  - start in the DONE cycle is ignored.
  - Input size changes after accept have no effect.
  - A single-tile job asserts tile_last with the first tile_valid.
  - tile_ready while tile_valid=0 has no effect.

Test Plan (SYS_ROWS=4, SYS_COLS=4, DIM_W=8):
1. start, ksize=3, nsize=4, ready=1 -> mode=11, if=0, w=1. One tile: base (0,0), rows 3, cols 4, last=1. done at t+3.
2. start, ksize=10, nsize=9, ready=1 -> mode=00, if=1, w=0. Nine tiles in order k_base 0,4,8 for each n_base 0,4,8. Rows 4,4,2; cols 4,4,1. last only on (8,8). done one cycle after it.
3. ksize=5, nsize=2; ready low for 5 cycles on tile 0 -> mode=01. Descriptor (0,0,4,2) held for all 6 cycles. Second tile (4,0,1,2,last) follows.
4. start, ksize=0, nsize=7 -> err pulse at t+1, busy stays 0, no tile_valid, mode unchanged.
5. start pulsed mid-ISSUE -> ignored, tile count unchanged. Async rst low mid-ISSUE -> tile_valid, busy, mode all 0 immediately; IDLE after release; a new job then runs normally.
6. ksize=255, nsize=255 -> mode=00, 64x64 tiles. Final tile (252,252) with rows 3, cols 3, last=1. No wrap; exactly 4096 handshakes.

Source files
------------

// File: rtl/tile_mode_sequencer.sv
// GEMM tile sequencer: classifies a (ksize, nsize) job into an array
// mode and walks it as array-sized tiles over a valid/ready handshake.
module tile_mode_sequencer #(
  parameter int SYS_ROWS = 4,
  parameter int SYS_COLS = 4,
  parameter int DIM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] ksize,
  input  logic [DIM_W-1:0] nsize,
  output logic             busy,
  output logic             err,
  output logic [1:0]       mode,
  output logic             if_mux_sel,
  output logic             w_mux_sel,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [DIM_W-1:0] tile_k_base,
  output logic [DIM_W-1:0] tile_n_base,
  output logic [DIM_W-1:0] tile_k_rows,
  output logic [DIM_W-1:0] tile_n_cols,
  output logic             tile_last,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ISSUE,
    FIN
  } state_t;

  localparam logic [DIM_W:0] ROWS_X =
    (DIM_W+1)'(SYS_ROWS);
  localparam logic [DIM_W:0] COLS_X =
    (DIM_W+1)'(SYS_COLS);

  state_t           state;
  logic [DIM_W-1:0] ksz;
  logic [DIM_W-1:0] nsz;
  logic [DIM_W-1:0] k_base;
  logic [DIM_W-1:0] n_base;

  logic [DIM_W:0]   k_sum;
  logic [DIM_W:0]   n_sum;
  logic [DIM_W-1:0] k_rem;
  logic [DIM_W-1:0] n_rem;
  logic             last_k;
  logic             last_n;
  logic             tall_in;
  logic             wide_in;
  logic             zero_in;

  // Sums carry one extra bit so bases near the top never wrap.
  assign k_sum  = {1'b0, k_base} + ROWS_X;
  assign n_sum  = {1'b0, n_base} + COLS_X;
  assign last_k = k_sum >= {1'b0, ksz};
  assign last_n = n_sum >= {1'b0, nsz};
  assign k_rem  = ksz - k_base;
  assign n_rem  = nsz - n_base;

  assign tall_in = {1'b0, ksize} <= ROWS_X;
  assign wide_in = {1'b0, nsize} > COLS_X;
  assign zero_in = (ksize == '0) || (nsize == '0);

  assign tile_k_base = k_base;
  assign tile_n_base = n_base;

  assign tile_k_rows =
    ({1'b0, k_rem} > ROWS_X) ?
    ROWS_X[DIM_W-1:0] : k_rem;
  assign tile_n_cols =
    ({1'b0, n_rem} > COLS_X) ?
    COLS_X[DIM_W-1:0] : n_rem;

  assign tile_last = tile_valid & last_k & last_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ksz        <= '0;
      nsz        <= '0;
      k_base     <= '0;
      n_base     <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      mode       <= 2'b00;
      if_mux_sel <= 1'b0;
      w_mux_sel  <= 1'b0;
      tile_valid <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && zero_in) begin
            err <= 1'b1;
          end else if (start) begin
            // Classify from the same values being latched.
            ksz        <= ksize;
            nsz        <= nsize;
            mode       <= {tall_in, ~wide_in};
            if_mux_sel <= ~tall_in;
            w_mux_sel  <= tall_in;
            busy       <= 1'b1;
            state      <= DECODE;
          end
        end
        DECODE: begin
          k_base     <= '0;
          n_base     <= '0;
          tile_valid <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          if (tile_ready) begin
            if (last_k && last_n) begin
              tile_valid <= 1'b0;
              done       <= 1'b1;
              state      <= FIN;
            end else if (last_k) begin
              k_base <= '0;
              n_base <= n_sum[DIM_W-1:0];
            end else begin
              k_base <= k_sum[DIM_W-1:0];
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_mode_sequencer.sv
// Self-checking bench for tile_mode_sequencer against a
// loop-based tile list model.
module tb_tile_mode_sequencer;

  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] kb;
    logic [W-1:0] nb;
    logic [W-1:0] rows;
    logic [W-1:0] cols;
    logic         last;
  } tile_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ksize = '0;
  logic [W-1:0] nsize = '0;
  logic         tile_ready = 1'b0;
  logic         busy;
  logic         err;
  logic [1:0]   mode;
  logic         if_mux_sel;
  logic         w_mux_sel;
  logic         tile_valid;
  logic [W-1:0] tile_k_base;
  logic [W-1:0] tile_n_base;
  logic [W-1:0] tile_k_rows;
  logic [W-1:0] tile_n_cols;
  logic         tile_last;
  logic         done;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_mode = 2'b00;
  tile_t exp_q[$];

  always #5 clk = ~clk;

  tile_mode_sequencer #(
    .SYS_ROWS(R),
    .SYS_COLS(C),
    .DIM_W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ksize(ksize),
    .nsize(nsize),
    .busy(busy),
    .err(err),
    .mode(mode),
    .if_mux_sel(if_mux_sel),
    .w_mux_sel(w_mux_sel),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_k_base(tile_k_base),
    .tile_n_base(tile_n_base),
    .tile_k_rows(tile_k_rows),
    .tile_n_cols(tile_n_cols),
    .tile_last(tile_last),
    .done(done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Tile list: N blocks outer, K blocks inner.
  task automatic build(input int k, input int n);
    tile_t t;
    exp_q.delete();
    for (int nb = 0; nb < n; nb += C) begin
      for (int kb = 0; kb < k; kb += R) begin
        t.kb   = W'(kb);
        t.nb   = W'(nb);
        t.rows = W'(imin(R, k - kb));
        t.cols = W'(imin(C, n - nb));
        t.last = (kb + R >= k) && (nb + C >= n);
        exp_q.push_back(t);
      end
    end
  endtask

  function automatic logic [1:0] mode_of(int k, int n);
    bit tall;
    bit wide;
    tall = (k <= R);
    wide = (n > C);
    if (!tall && wide)  return 2'b00;
    if (!tall && !wide) return 2'b01;
    if (tall && wide)   return 2'b10;
    return 2'b11;
  endfunction

  // rmode: 0 ready high, 1 random, 2 low for first 5 cycles
  task automatic run_job(input int k, input int n,
                         input int rmode,
                         input bit poke_issue,
                         input bit poke_done);
    int cyc;
    int bound;
    int err0;
    build(k, n);
    exp_mode = mode_of(k, n);
    bound = 4 * exp_q.size() + 50;
    err0 = errors;
    start = 1'b1;
    ksize = W'(k);
    nsize = W'(n);
    step();
    start = 1'b0;
    ksize = W'($urandom);
    nsize = W'($urandom);
    chk("busy_decode", busy, 1);
    chk("mode", mode, exp_mode);
    chk("if_sel", if_mux_sel, !(k <= R));
    chk("w_sel", w_mux_sel, (k <= R));
    chk("valid_decode", tile_valid, 0);
    step();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < bound &&
           errors - err0 < 20) begin
      unique case (rmode)
        1:       tile_ready = 1'($urandom_range(0, 1));
        2:       tile_ready = (cyc >= 5);
        default: tile_ready = 1'b1;
      endcase
      if (poke_issue && cyc == 2) begin
        start = 1'b1;
        ksize = 8'd1;
        nsize = 8'd1;
      end else begin
        start = 1'b0;
      end
      chk("tile",
          {tile_valid, tile_k_base, tile_n_base,
           tile_k_rows, tile_n_cols, tile_last},
          {1'b1, exp_q[0]});
      chk("busy_issue", busy, 1);
      chk("mode_hold", mode, exp_mode);
      if (tile_valid && tile_ready)
        void'(exp_q.pop_front());
      step();
      cyc++;
    end
    start = 1'b0;
    tile_ready = 1'b0;
    if (exp_q.size() != 0)
      chk("tiles_left", exp_q.size(), 0);
    chk("done", done, 1);
    chk("busy_done", busy, 1);
    chk("valid_done", tile_valid, 0);
    if (poke_done) begin
      start = 1'b1;
      ksize = 8'd2;
      nsize = 8'd2;
    end
    step();
    start = 1'b0;
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    step();
    chk("busy_idle2", busy, 0);
    chk("valid_idle", tile_valid, 0);
    chk("mode_idle", mode, exp_mode);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", tile_valid, 0);
    chk("rst_mode", mode, 0);
    chk("rst_sels", {if_mux_sel, w_mux_sel}, 0);
    chk("rst_err_done", {err, done}, 0);
    chk("rst_last", tile_last, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    run_job(3, 4, 0, 0, 0);
    run_job(10, 9, 0, 0, 1);
    run_job(5, 2, 2, 0, 0);

    // zero size is rejected, mode retained
    start = 1'b1;
    ksize = 8'd0;
    nsize = 8'd7;
    step();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", tile_valid, 0);
    chk("err_mode", mode, exp_mode);
    step();
    chk("err_clear", err, 0);
    chk("err_busy2", busy, 0);

    run_job(12, 7, 0, 1, 0);

    // async reset in the middle of a job
    start = 1'b1;
    ksize = 8'd12;
    nsize = 8'd12;
    step();
    start = 1'b0;
    tile_ready = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_valid", tile_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", tile_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mode", mode, 0);
    chk("arst_kbase", tile_k_base, 0);
    exp_mode = 2'b00;
    tile_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", tile_valid, 0);
    run_job(6, 3, 0, 0, 0);

    for (int j = 0; j < 10; j++)
      run_job($urandom_range(1, 24),
              $urandom_range(1, 24), 1,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));

    run_job(255, 255, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
